col_wr_demux: RTL and testbench

- Write-side counterpart of the memory column read mux: a 1-to-NUM_ELEM write decoder/driver for one memory column.
- Accepts a write request (address + data) over a valid/ready handshake.
- Broadcasts the data onto the shared column data bus and sequences a timed one-hot write-enable pulse to the addressed element: setup, then pulse, then hold.
- Sits between the column controller and the storage element array.

---
 rtl/col_wr_demux_if.sv | 44 ++++
 rtl/col_wr_demux.sv | 175 +++++++++++++++++
 tb/tb_col_wr_demux.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/col_wr_demux_if.sv
// Request/column bus bundle for col_wr_demux.
// master: column controller side (drives the request, observes the column outputs).
// slave : col_wr_demux itself.
// Signals: addr_i/data_i/valid_i request, ready_o acceptance, col_data_o shared
// data bus, col_we_o per-element write enables, done_o/err_o completion pulses.
// With COL_WR_DEMUX_BCAST_EN defined, bcast_i (write every element) is added.
interface col_wr_demux_if #(
  parameter int unsigned ELEM_WIDTH = 1,
  parameter int unsigned NUM_ELEM   = 1024
);
  localparam int unsigned ADDR_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;

  logic [ADDR_W-1:0]     addr_i;
  logic [ELEM_WIDTH-1:0] data_i;
  logic                  valid_i;
  logic                  ready_o;
  logic [ELEM_WIDTH-1:0] col_data_o;
  logic [NUM_ELEM-1:0]   col_we_o;
  logic                  done_o;
  logic                  err_o;
`ifdef COL_WR_DEMUX_BCAST_EN
  logic                  bcast_i;

  modport master (
    output addr_i, data_i, valid_i, bcast_i,
    input  ready_o, col_data_o, col_we_o, done_o, err_o
  );

  modport slave (
    input  addr_i, data_i, valid_i, bcast_i,
    output ready_o, col_data_o, col_we_o, done_o, err_o
  );
`else
  modport master (
    output addr_i, data_i, valid_i,
    input  ready_o, col_data_o, col_we_o, done_o, err_o
  );

  modport slave (
    input  addr_i, data_i, valid_i,
    output ready_o, col_data_o, col_we_o, done_o, err_o
  );
`endif
endinterface

// File: rtl/col_wr_demux.sv
// col_wr_demux: 1-to-NUM_ELEM write decoder/driver for one memory column.
// A request (addr, data) is accepted over valid/ready; the data is placed on the
// shared column bus, then a timed one-hot write enable is sequenced to the
// addressed element: SETUP_CYCLES of setup, PULSE_CYCLES of pulse, one HOLD cycle
// with done_o (and err_o if the address is beyond the column).
// Ports: clk_i clock, arst_i async active-high reset, bus (col_wr_demux_if.slave).
// Optional: COL_WR_DEMUX_BCAST_EN adds bcast_i, which enables every element.
// All outputs are registered.
module col_wr_demux #(
  parameter int unsigned ELEM_WIDTH   = 1,
  parameter int unsigned NUM_ELEM     = 1024,
  parameter int unsigned SETUP_CYCLES = 1,
  parameter int unsigned PULSE_CYCLES = 2
) (
  input  logic          clk_i,
  input  logic          arst_i,
  col_wr_demux_if.slave bus
);

  localparam int unsigned ADDR_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
  localparam int unsigned MAX_CYC = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int unsigned CNT_W  = (MAX_CYC > 0) ? $clog2(MAX_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [ELEM_WIDTH-1:0] data_q, data_d;
  logic                  ready_q, ready_d;
  logic [NUM_ELEM-1:0]   we_q, we_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  addr_bad_c;
  logic                  all_en_c;

  // Out-of-range detection only exists when the address space exceeds the column
  generate
    if (NUM_ELEM == (1 << ADDR_W)) begin : g_full_range
      assign addr_bad_c = 1'b0;
    end else begin : g_part_range
      assign addr_bad_c = (addr_q >= ADDR_W'(NUM_ELEM));
    end
  endgenerate

`ifdef COL_WR_DEMUX_BCAST_EN
  logic bcast_q, bcast_d;

  // Broadcast latched with the request
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      bcast_q <= 1'b0;
    end else begin
      bcast_q <= bcast_d;
    end
  end

  always_comb begin
    bcast_d = bcast_q;
    if (state_q == IDLE && bus.valid_i && ready_q) begin
      bcast_d = bus.bcast_i;
    end
  end

  assign all_en_c = bcast_q;
`else
  assign all_en_c = 1'b0;
`endif

  // State, counter, latched request and registered outputs
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      ready_q <= 1'b1;
      we_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next state; outputs are computed from the next state so they register in step
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ready_d = 1'b0;
    we_d    = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.valid_i && ready_q) begin
          addr_d  = bus.addr_i;
          data_d  = bus.data_i;
          cnt_d   = SETUP_LOAD;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          cnt_d   = PULSE_LOAD;
          state_d = PULSE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          cnt_d   = '0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);

    // addr_q is stable from SETUP onwards, so it is safe to decode here
    if (state_d == PULSE) begin
      if (all_en_c) begin
        we_d = '1;
      end else if (!addr_bad_c) begin
        we_d[addr_q] = 1'b1;
      end
    end

    done_d = (state_d == HOLD);
    err_d  = (state_d == HOLD) && addr_bad_c && !all_en_c;
  end

  assign bus.ready_o    = ready_q;
  assign bus.col_data_o = data_q;
  assign bus.col_we_o   = we_q;
  assign bus.done_o     = done_q;
  assign bus.err_o      = err_q;

  // Enables only ever appear while pulsing
  a_we_only_in_pulse: assert property (@(posedge clk_i) disable iff (arst_i)
    (|we_q) |-> (state_q == PULSE));

  // At most one element enabled unless broadcasting
  a_we_onehot0: assert property (@(posedge clk_i) disable iff (arst_i)
    all_en_c || $onehot0(we_q));

endmodule

// File: tb/tb_col_wr_demux.sv
// Self-checking bench for col_wr_demux: randomised requests checked against a
// timeline model (accept edge + fixed phase lengths), plus directed scenarios.
module tb_col_wr_demux;

  localparam int unsigned EW   = 1;
  localparam int unsigned NE   = 1024;
  localparam int unsigned NE_B = 1000;
  localparam int unsigned S    = 1;
  localparam int unsigned P    = 2;
  localparam int unsigned AW   = 10;

  logic clk;
  logic rst;

  col_wr_demux_if #(.ELEM_WIDTH(EW), .NUM_ELEM(NE))   bus ();
  col_wr_demux_if #(.ELEM_WIDTH(EW), .NUM_ELEM(NE_B)) bus_b ();

  col_wr_demux #(.ELEM_WIDTH(EW), .NUM_ELEM(NE), .SETUP_CYCLES(S), .PULSE_CYCLES(P)) dut (
    .clk_i (clk),
    .arst_i(rst),
    .bus   (bus)
  );

  col_wr_demux #(.ELEM_WIDTH(EW), .NUM_ELEM(NE_B), .SETUP_CYCLES(S), .PULSE_CYCLES(P)) dut_b (
    .clk_i (clk),
    .arst_i(rst),
    .bus   (bus_b)
  );

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] last_data;
  logic [EW-1:0] last_data_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NE-1:0] onehot(input int unsigned a);
    logic [NE-1:0] v;
    logic [AW-1:0] ai;
    v  = '0;
    ai = AW'(a);
    if (a < NE) v[ai] = 1'b1;
    return v;
  endfunction

  function automatic logic [NE_B-1:0] onehot_b(input int unsigned a);
    logic [NE_B-1:0] v;
    logic [AW-1:0]   ai;
    v  = '0;
    ai = AW'(a);
    if (a < NE_B) v[ai] = 1'b1;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full write on the main DUT; starts and ends one step after an edge with the DUT idle
  task automatic run_txn(input int unsigned a, input logic [EW-1:0] d, input bit bc, input bit hold_valid);
    logic [NE-1:0] exp_we;
    bus.addr_i  = AW'(a);
    bus.data_i  = d;
    bus.valid_i = 1'b1;
`ifdef COL_WR_DEMUX_BCAST_EN
    bus.bcast_i = bc;
`endif
    tick;
    last_data = d;
    for (int t = 1; t <= int'(S + P + 1); t++) begin
      exp_we = (t > int'(S) && t <= int'(S + P)) ? (bc ? '1 : onehot(a)) : '0;
      checks++;
      if (bus.col_we_o !== exp_we) begin
        errors++;
        $display("FAIL col_we t=%0d addr=%0d: got ones=%0d bit=%b, expected ones=%0d bit=%b",
                 t, a, $countones(bus.col_we_o), bus.col_we_o[AW'(a)], $countones(exp_we), exp_we[AW'(a)]);
      end
      checks++;
      if (bus.ready_o !== 1'b0) begin
        errors++;
        $display("FAIL ready_busy t=%0d addr=%0d: got %b expected 0", t, a, bus.ready_o);
      end
      checks++;
      if (bus.col_data_o !== last_data) begin
        errors++;
        $display("FAIL col_data t=%0d addr=%0d: got %h expected %h", t, a, bus.col_data_o, last_data);
      end
      checks++;
      if (bus.done_o !== (t == int'(S + P + 1))) begin
        errors++;
        $display("FAIL done t=%0d addr=%0d: got %b expected %b", t, a, bus.done_o, t == int'(S + P + 1));
      end
      checks++;
      if (bus.err_o !== 1'b0) begin
        errors++;
        $display("FAIL err t=%0d addr=%0d: got %b expected 0", t, a, bus.err_o);
      end
      // Inputs wander while busy; none of this may be picked up
      bus.addr_i  = AW'($urandom);
      bus.data_i  = EW'($urandom);
      bus.valid_i = hold_valid ? 1'b1 : 1'($urandom);
`ifdef COL_WR_DEMUX_BCAST_EN
      bus.bcast_i = 1'($urandom);
`endif
      tick;
    end
    bus.valid_i = 1'b0;
    checks++;
    if (bus.ready_o !== 1'b1 || bus.col_we_o !== '0 || bus.done_o !== 1'b0 || bus.col_data_o !== last_data) begin
      errors++;
      $display("FAIL return_idle addr=%0d: got ready=%b we_ones=%0d done=%b data=%h expected ready=1 we_ones=0 done=0 data=%h",
               a, bus.ready_o, $countones(bus.col_we_o), bus.done_o, bus.col_data_o, last_data);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    checks++;
    if (bus.ready_o !== 1'b1 || bus.col_we_o !== '0 || bus.col_data_o !== '0 || bus.done_o !== 1'b0 || bus.err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got ready=%b we_ones=%0d data=%h done=%b err=%b expected 1 0 0 0 0",
               bus.ready_o, $countones(bus.col_we_o), bus.col_data_o, bus.done_o, bus.err_o);
    end
    checks++;
    if (bus_b.ready_o !== 1'b1 || bus_b.col_we_o !== '0 || bus_b.done_o !== 1'b0 || bus_b.err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_values_b: got ready=%b we_ones=%0d done=%b err=%b expected 1 0 0 0",
               bus_b.ready_o, $countones(bus_b.col_we_o), bus_b.done_o, bus_b.err_o);
    end
    rst = 1'b0;
    last_data   = '0;
    last_data_b = '0;
    for (int i = 0; i < 5; i++) begin
      bus.addr_i = AW'($urandom);
      bus.data_i = EW'($urandom);
      tick;
      checks++;
      if (bus.ready_o !== 1'b1 || bus.col_we_o !== '0 || bus.col_data_o !== '0 || bus.done_o !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset cycle=%0d: got ready=%b we_ones=%0d data=%h done=%b expected 1 0 0 0",
                 i, bus.ready_o, $countones(bus.col_we_o), bus.col_data_o, bus.done_o);
      end
    end
  endtask

  task automatic test_single;
    run_txn(700, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_txn(0, 1'b1, 1'b0, 1'b1);
    run_txn(NE - 1, 1'b0, 1'b0, 1'b0);
    run_txn(NE - 1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    int unsigned gap;
    for (int n = 0; n < 40; n++) begin
      run_txn($urandom_range(NE - 1, 0), EW'($urandom), 1'b0, 1'($urandom));
      gap = $urandom_range(3, 0);
      for (int g = 0; g < int'(gap); g++) begin
        bus.addr_i  = AW'($urandom);
        bus.data_i  = EW'($urandom);
        bus.valid_i = 1'b0;
        tick;
        checks++;
        if (bus.ready_o !== 1'b1 || bus.col_we_o !== '0 || bus.done_o !== 1'b0 || bus.col_data_o !== last_data) begin
          errors++;
          $display("FAIL idle_gap n=%0d: got ready=%b we_ones=%0d done=%b data=%h expected 1 0 0 %h",
                   n, bus.ready_o, $countones(bus.col_we_o), bus.done_o, bus.col_data_o, last_data);
        end
      end
    end
  endtask

  // One write on the 1000-element DUT, including addresses past the end of the column
  task automatic run_txn_b(input int unsigned a, input logic [EW-1:0] d, input bit bc);
    logic [NE_B-1:0] exp_we;
    logic            exp_err;
    bus_b.addr_i  = AW'(a);
    bus_b.data_i  = d;
    bus_b.valid_i = 1'b1;
`ifdef COL_WR_DEMUX_BCAST_EN
    bus_b.bcast_i = bc;
`endif
    tick;
    bus_b.valid_i = 1'b0;
    last_data_b   = d;
    for (int t = 1; t <= int'(S + P + 2); t++) begin
      exp_we  = (t > int'(S) && t <= int'(S + P)) ? (bc ? '1 : onehot_b(a)) : '0;
      exp_err = (t == int'(S + P + 1)) && (a >= NE_B) && !bc;
      checks++;
      if (bus_b.col_we_o !== exp_we) begin
        errors++;
        $display("FAIL col_we_b t=%0d addr=%0d: got ones=%0d expected ones=%0d",
                 t, a, $countones(bus_b.col_we_o), $countones(exp_we));
      end
      checks++;
      if (bus_b.done_o !== (t == int'(S + P + 1)) || bus_b.err_o !== exp_err) begin
        errors++;
        $display("FAIL done_err_b t=%0d addr=%0d: got done=%b err=%b expected done=%b err=%b",
                 t, a, bus_b.done_o, bus_b.err_o, t == int'(S + P + 1), exp_err);
      end
      checks++;
      if (bus_b.ready_o !== (t == int'(S + P + 2)) || bus_b.col_data_o !== last_data_b) begin
        errors++;
        $display("FAIL ready_data_b t=%0d addr=%0d: got ready=%b data=%h expected ready=%b data=%h",
                 t, a, bus_b.ready_o, bus_b.col_data_o, t == int'(S + P + 2), last_data_b);
      end
      if (t < int'(S + P + 2)) tick;
    end
  endtask

  task automatic test_out_of_range;
    run_txn_b(1010, 1'b1, 1'b0);
    run_txn_b(NE_B - 1, 1'b0, 1'b0);
    run_txn_b(NE_B, 1'b1, 1'b0);
    run_txn_b(0, 1'b1, 1'b0);
  endtask

`ifdef COL_WR_DEMUX_BCAST_EN
  task automatic test_bcast;
    run_txn($urandom_range(NE - 1, 0), 1'b0, 1'b1, 1'b0);
    run_txn(3, 1'b1, 1'b0, 1'b0);
    run_txn_b(1010, 1'b0, 1'b1);
  endtask
`endif

  task automatic test_async_reset;
    bus.addr_i  = AW'(5);
    bus.data_i  = 1'b1;
    bus.valid_i = 1'b1;
`ifdef COL_WR_DEMUX_BCAST_EN
    bus.bcast_i = 1'b0;
`endif
    tick;
    bus.valid_i = 1'b0;
    for (int i = 0; i < int'(S + 1); i++) tick;
    checks++;
    if (bus.col_we_o !== onehot(5)) begin
      errors++;
      $display("FAIL pulse_before_reset: got ones=%0d bit5=%b expected ones=1 bit5=1",
               $countones(bus.col_we_o), bus.col_we_o[5]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.col_we_o !== '0 || bus.ready_o !== 1'b1) begin
      errors++;
      $display("FAIL async_reset_drop: got we_ones=%0d ready=%b expected 0 1",
               $countones(bus.col_we_o), bus.ready_o);
    end
    tick;
    rst = 1'b0;
    last_data = '0;
    for (int i = 0; i < int'(S + P + 3); i++) begin
      tick;
      checks++;
      if (bus.done_o !== 1'b0 || bus.err_o !== 1'b0 || bus.ready_o !== 1'b1 ||
          bus.col_we_o !== '0 || bus.col_data_o !== '0) begin
        errors++;
        $display("FAIL after_reset cycle=%0d: got done=%b err=%b ready=%b we_ones=%0d data=%h expected 0 0 1 0 0",
                 i, bus.done_o, bus.err_o, bus.ready_o, $countones(bus.col_we_o), bus.col_data_o);
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.addr_i    = '0;
    bus.data_i    = '0;
    bus.valid_i   = 1'b0;
    bus_b.addr_i  = '0;
    bus_b.data_i  = '0;
    bus_b.valid_i = 1'b0;
`ifdef COL_WR_DEMUX_BCAST_EN
    bus.bcast_i   = 1'b0;
    bus_b.bcast_i = 1'b0;
`endif
    last_data     = '0;
    last_data_b   = '0;

    test_reset;
    test_single;
    test_back_to_back;
    test_random;
    test_out_of_range;
`ifdef COL_WR_DEMUX_BCAST_EN
    test_bcast;
`endif
    test_async_reset;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
